// File: rtl/seven_segment_scan_ctrl_if.sv
// Scanner bus: producer-side scan controls and decoder-side display outputs.
interface seven_segment_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    pending;
    logic                    frame_start;

    modport master (
        output enable, load, value,
        input  bcd_out, digit_en, pending, frame_start
    );

    modport slave (
        input  enable, load, value,
        output bcd_out, digit_en, pending, frame_start
    );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with blanking gaps and tear-free frame commits.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seven_segment_scan_ctrl_if.slave     bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

    state_t                      state, state_nx;
    logic [NUM_DIGITS-1:0][3:0]  pend_val, disp_val, disp_nx;
    logic [NUM_DIGITS-1:0]       blank_mask, mask_nx;
    logic [IDX_W-1:0]            idx, idx_nx;
    logic [CNT_W-1:0]            dwell, dwell_nx;
    logic                        pend_flag, commit;
    logic [NUM_DIGITS-1:0]       digit_sel, digit_nx;
    logic [3:0]                  bcd_nib, bcd_nx;
    logic                        frame_pulse;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zeros from the top digit down until the first nonzero; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] leading_blank(
        input logic [NUM_DIGITS-1:1][3:0] v
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            run  = run & (v[d] == 4'h0);
            m[d] = run;
        end
        return m;
    endfunction
`endif

    always_comb begin
        commit  = (state == S_GAP) && (idx == '0) && pend_flag;
        disp_nx = commit ? pend_val : disp_val;
`ifdef LEADING_ZERO_BLANK_EN
        mask_nx = commit ? leading_blank(pend_val[NUM_DIGITS-1:1]) : blank_mask;
`else
        mask_nx = blank_mask;
`endif

        state_nx = state;
        idx_nx   = idx;
        dwell_nx = dwell;
        if (!bus.enable) begin
            state_nx = S_OFF;
            idx_nx   = '0;
            dwell_nx = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nx = S_GAP;
                    idx_nx   = '0;
                    dwell_nx = '0;
                end
                S_GAP: begin
                    state_nx = S_SHOW;
                    dwell_nx = '0;
                end
                S_SHOW: begin
                    if (dwell == DWELL_LAST) begin
                        state_nx = S_GAP;
                        dwell_nx = '0;
                        idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        dwell_nx = dwell + 1'b1;
                    end
                end
                default: begin
                    state_nx = S_OFF;
                    idx_nx   = '0;
                    dwell_nx = '0;
                end
            endcase
        end

        // Outputs are computed for the state being entered so they appear with it.
        digit_nx = '0;
        bcd_nx   = 4'hF;
        if (state_nx == S_SHOW) begin
            digit_nx = NUM_DIGITS'(1) << idx_nx;
            if (!mask_nx[idx_nx])
                bcd_nx = disp_nx[idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Park dark so the first clocked cycle after release is the frame-start GAP.
            state       <= S_OFF;
            idx         <= '0;
            dwell       <= '0;
            pend_val    <= '0;
            disp_val    <= '0;
            blank_mask  <= '0;
            pend_flag   <= 1'b0;
            digit_sel   <= '0;
            bcd_nib     <= 4'hF;
            frame_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            dwell       <= dwell_nx;
            disp_val    <= disp_nx;
            blank_mask  <= mask_nx;
            digit_sel   <= digit_nx;
            bcd_nib     <= bcd_nx;
            frame_pulse <= (state_nx == S_GAP) && (idx_nx == '0);
            if (bus.load) begin
                pend_val  <= bus.value;
                pend_flag <= 1'b1;
            end else if (commit) begin
                pend_flag <= 1'b0;
            end
        end
    end

    assign bus.digit_en    = digit_sel;
    assign bus.bcd_out     = bcd_nib;
    assign bus.pending     = pend_flag;
    assign bus.frame_start = frame_pulse;
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench for seven_segment_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seven_segment_scan_ctrl;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int DPER  = RD + 1;
    localparam int FRAME = ND * DPER;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_on   = 1'b0;

    seven_segment_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: position within the frame (-1 = dark/off), phase 0 of each digit period is the gap.
    int          pos;
    bit          m_pend;
    logic [15:0] m_pval, m_disp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    = -1;
            m_pend = 1'b0;
            m_pval = '0;
            m_disp = '0;
        end else begin
            if (pos == 0 && m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end
            if (bus.load) begin
                m_pval = bus.value;
                m_pend = 1'b1;
            end
            if (!bus.enable)  pos = -1;
            else if (pos < 0) pos = 0;
            else              pos = (pos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [3:0] e_en, e_bcd;
            logic       e_fs;
            int         d;
            e_en  = '0;
            e_bcd = 4'hF;
            e_fs  = (pos == 0);
            if (pos >= 0 && (pos % DPER) != 0) begin
                d     = pos / DPER;
                e_en  = 4'(1 << d);
                e_bcd = 4'((m_disp >> (4 * d)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
                if (d > 0 && (m_disp >> (4 * d)) == 16'h0) e_bcd = 4'hF;
`endif
            end
            checks++;
            if (bus.digit_en !== e_en || bus.bcd_out !== e_bcd ||
                bus.frame_start !== e_fs || bus.pending !== m_pend) begin
                failures++;
                $display("FAIL model t=%0t: got en=%b bcd=%h fs=%b pend=%b, expected en=%b bcd=%h fs=%b pend=%b",
                         $time, bus.digit_en, bus.bcd_out, bus.frame_start, bus.pending,
                         e_en, e_bcd, e_fs, m_pend);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (bus.frame_start !== 1'b1) begin
            failures++;
            $display("FAIL frame_start_timeout: got no pulse in %0d cycles, expected one", n);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        tick(1);
        bus.load  = 1'b0;
    endtask

    initial begin
        int off_cnt;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.value  = '0;
        off_cnt    = 0;
        tick(1);
        chk_on = 1'b1;
        tick(2);
        check("rst_digit_en", 32'(bus.digit_en), 0);
        check("rst_bcd", 32'(bus.bcd_out), 32'hF);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_frame_start", 32'(bus.frame_start), 0);

        rst_n      = 1'b1;
        bus.enable = 1'b1;
        tick(1);
        check("first_gap_fs", 32'(bus.frame_start), 1);
        check("first_gap_en", 32'(bus.digit_en), 0);
        tick(1);
        check("first_digit_en", 32'(bus.digit_en), 32'h1);
        check("first_digit_bcd", 32'(bus.bcd_out), 0);

        do_load(16'h1234);
        check("pend_after_load", 32'(bus.pending), 1);
        wait_fs();
        check("pend_in_commit_gap", 32'(bus.pending), 1);
        for (int k = 1; k <= FRAME; k++) begin
            tick(1);
            case (k)
                1:  begin check("f_d0_en", 32'(bus.digit_en), 32'h1); check("f_d0_bcd", 32'(bus.bcd_out), 4);
                          check("f_pend_clear", 32'(bus.pending), 0); end
                4:  begin check("f_d0_last_en", 32'(bus.digit_en), 32'h1); check("f_d0_last_bcd", 32'(bus.bcd_out), 4); end
                5:  begin check("f_gap_en", 32'(bus.digit_en), 0); check("f_gap_bcd", 32'(bus.bcd_out), 32'hF);
                          check("f_gap_fs", 32'(bus.frame_start), 0); end
                6:  begin check("f_d1_en", 32'(bus.digit_en), 32'h2); check("f_d1_bcd", 32'(bus.bcd_out), 3); end
                11: begin check("f_d2_en", 32'(bus.digit_en), 32'h4); check("f_d2_bcd", 32'(bus.bcd_out), 2); end
                16: begin check("f_d3_en", 32'(bus.digit_en), 32'h8); check("f_d3_bcd", 32'(bus.bcd_out), 1); end
                20: check("f_wrap_fs", 32'(bus.frame_start), 1);
                default: ;
            endcase
        end

        tick(7);
        do_load(16'h5678);
        check("mid_pending", 32'(bus.pending), 1);
        check("mid_no_tear", 32'(bus.bcd_out), 3);
        wait_fs();
        tick(1);
        check("new_d0", 32'(bus.bcd_out), 8);
        check("new_pend_clear", 32'(bus.pending), 0);

        do_load(16'h1111);
        tick(2);
        do_load(16'h2222);
        wait_fs();
        tick(1);
        check("last_wins_d0", 32'(bus.bcd_out), 2);
        tick(5);
        check("last_wins_d1", 32'(bus.bcd_out), 2);

        do_load(16'h0070);
        wait_fs();
        tick(1);
        check("lz_d0", 32'(bus.bcd_out), 0);
        tick(5);
        check("lz_d1", 32'(bus.bcd_out), 7);
        tick(5);
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d2", 32'(bus.bcd_out), 32'hF);
        tick(5);
        check("lz_d3", 32'(bus.bcd_out), 32'hF);
`else
        check("lz_d2", 32'(bus.bcd_out), 0);
        tick(5);
        check("lz_d3", 32'(bus.bcd_out), 0);
`endif

        for (int i = 0; i < 800; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.value = 16'($urandom) & 16'h00FF;
            else                           bus.value = 16'($urandom);
            if (off_cnt > 0) begin
                off_cnt--;
                bus.enable = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                off_cnt    = $urandom_range(1, 5);
                bus.enable = 1'b0;
            end else begin
                bus.enable = 1'b1;
            end
            tick(1);
        end
        bus.load   = 1'b0;
        bus.enable = 1'b1;

        wait_fs();
        tick(2);
        bus.enable = 1'b0;
        tick(1);
        check("dis_en", 32'(bus.digit_en), 0);
        check("dis_bcd", 32'(bus.bcd_out), 32'hF);
        tick(2);
        bus.enable = 1'b1;
        tick(1);
        check("reen_fs", 32'(bus.frame_start), 1);
        check("reen_gap_en", 32'(bus.digit_en), 0);
        tick(1);
        check("reen_d0_en", 32'(bus.digit_en), 32'h1);

        do_load(16'h9999);
        check("pre_rst_pending", 32'(bus.pending), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(bus.digit_en), 0);
        check("async_rst_bcd", 32'(bus.bcd_out), 32'hF);
        check("async_rst_pending", 32'(bus.pending), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_fs", 32'(bus.frame_start), 1);
        tick(1);
        check("post_rst_d0_en", 32'(bus.digit_en), 32'h1);
        check("post_rst_d0_bcd", 32'(bus.bcd_out), 0);
        tick(2);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_segment_scan_ctrl.md
# seven_segment_scan_ctrl

Time-multiplexed display scanner that shares one BCD-to-seven-segment decoder across `NUM_DIGITS` common-cathode digits. It holds a frame of BCD digits and presents one nibble at a time on `bcd_out` with a one-hot digit enable. It inserts a blanking gap between digits to suppress ghosting. New values are committed only at frame boundaries, so a displayed frame never tears. It sits between the value producer (counter or register file) and the decoder/digit drivers.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 2..8.
- `REFRESH_DIV`, default 1000: clock cycles each digit is lit; must be at least 1.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; reset is asynchronous and active-low.
- `enable`  in  1  scan enable; low forces the display dark.
- `load`  in  1  one-cycle strobe that captures `value` into the pending register.
- `value`  in  4*NUM_DIGITS  BCD digits; nibble 0 is the least-significant, rightmost digit.
- `bcd_out`  out  4  nibble to the decoder; 4'hF means blank, and the decoder outputs all segments off.
- `digit_en`  out  NUM_DIGITS  one-hot active-high digit select; all zero when dark.
- `pending`  out  1  high while a loaded value awaits commit.
- `frame_start`  out  1  one-cycle pulse in the GAP cycle preceding digit 0.

## Operation
- Registers:
  - `pend_val`: pending value.
  - `disp_val`: displayed value.
  - `blank_mask`: NUM_DIGITS bits.
  - `idx`: current digit.
  - Dwell counter, width $clog2(REFRESH_DIV+1).
  - State.
- States:
  - OFF: dark.
  - GAP: one dark cycle.
  - SHOW: digit lit.
- Transitions:
  - Reset → GAP with idx=0.
  - GAP → SHOW after exactly 1 cycle, same idx.
  - SHOW → GAP after REFRESH_DIV cycles. idx increments on leaving SHOW and wraps from NUM_DIGITS-1 to 0.
  - Any state → OFF when `enable`=0.
  - OFF → GAP with idx=0 when `enable`=1.
- Outputs by state:
  - GAP and OFF: digit_en=0, bcd_out=4'hF.
  - SHOW: digit_en=1<<idx. bcd_out = disp_val[idx]; if blank_mask[idx] is set, bcd_out=4'hF instead.
- Load:
  - On `load`, pend_val←value and pending←1.
  - A second load before commit overwrites pend_val. The last load wins.
- Commit:
  - Happens in any GAP cycle with idx=0 and pending=1.
  - disp_val←pend_val, blank_mask is recomputed, and pending←0.
  - If `load` occurs in the same cycle, commit uses the old pend_val, the new value lands in pend_val, and pending stays 1.
- Nibbles 4'hA–4'hF pass through unmodified. The decoder renders them blank.
- No commit occurs in OFF. A pending value waits for the first GAP with idx=0 after re-enable.

## Timing
- All outputs are registered. Each state's output values appear in the same cycle the state is held.
- Reset values:
  - digit_en=0, bcd_out=4'hF, pending=0, frame_start=0.
  - disp_val=0, pend_val=0, blank_mask=0, idx=0, counter=0.
- Reset asserted mid-scan takes effect immediately, asynchronously. The first cycle after release is GAP with idx=0, and frame_start=1 in that cycle.
- Scan timing:
  - Digit period is REFRESH_DIV+1 cycles.
  - Frame is NUM_DIGITS*(REFRESH_DIV+1) cycles.
  - frame_start pulses once per frame.
- Load-to-display latency:
  - Minimum 1 cycle: load lands in the cycle before a commit GAP.
  - Maximum one frame plus 1 cycle.
- Disable: the cycle after `enable` falls shows OFF outputs. The dwell counter clears.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - At commit, digits from NUM_DIGITS-1 downward that are 4'h0 set blank_mask, stopping at the first nonzero digit.
  - Digit 0 is never blanked.
- `LEADING_ZERO_BLANK_EN` undefined: blank_mask is held at 0 and all digits display.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset, enable=1, load 16'h1234 → commit at next idx-0 GAP. Sequence per frame:
  - bcd 4 with en 0001 ×4 cycles, then GAP.
  - 3 with 0010, then GAP.
  - 2 with 0100, then GAP.
  - 1 with 1000.
  - Frame is 20 cycles.
- Load 16'h5678 during digit 1 → pending=1. Digits keep showing 1234 until the wrap GAP, then 5678. pending=0 at commit.
- Load 16'h1111, then 16'h2222 three cycles later, both before commit → only 2222 is displayed.
- Load 16'h0070:
  - With the macro: digits 3 and 2 output 4'hF, digit 1 shows 7, digit 0 shows 0.
  - Without the macro: 0, 0, 7, 0.
- Drop enable mid-SHOW → next cycle digit_en=0, bcd_out=F. Raise enable → one GAP with frame_start=1, then digit 0.
- Assert rst_n low mid-SHOW → immediately digit_en=0, bcd_out=F, pending=0. After release, disp_val=0 and digit 0 shows 0.
